// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, addresses the program ROM, fills the IF/ID register, counts fetches.
// Latency: the word at PCAddress reaches IFID_Instruction one clock later.
// Backpressure: Stall freezes PC and IF/ID; Redirect reloads PC and bubbles IF/ID; a fault freezes all until reset.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    COUNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Stall,
    input  logic                   Redirect,
    input  logic [DATA_WIDTH-1:0]  RedirectTarget,
    input  logic [DATA_WIDTH-1:0]  Instruction,
    output logic [DATA_WIDTH-1:0]  PCAddress,
    output logic [DATA_WIDTH-1:0]  IFID_Instruction,
    output logic [DATA_WIDTH-1:0]  IFID_PC_4,
    output logic                   IFID_Valid,
    output logic                   FetchFault,
    output logic [COUNT_WIDTH-1:0] FetchCount
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    localparam logic [DATA_WIDTH-3:0] DEPTH_W = (DATA_WIDTH-2)'(MEMORY_DEPTH);

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   pc, pc_nxt, pc_plus4;
    logic [DATA_WIDTH-1:0]   ins_nxt, pc4_nxt;
    logic                    vld_nxt;
    logic [COUNT_WIDTH-1:0]  cnt_nxt;
    logic                    pc_bad;

    assign pc_plus4   = pc + DATA_WIDTH'(4);
    // A wrapped PC+4 lands at a low word index only if DATA_WIDTH is tiny; the range test covers it.
    assign pc_bad     = (pc[1:0] != 2'b00) || (pc[DATA_WIDTH-1:2] >= DEPTH_W);
    assign PCAddress  = pc;
    assign FetchFault = (state == FAULT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ins_nxt   = IFID_Instruction;
        pc4_nxt   = IFID_PC_4;
        vld_nxt   = IFID_Valid;
        cnt_nxt   = FetchCount;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (pc_bad) begin
                    state_nxt = FAULT;
                    ins_nxt   = NOP_WORD;
                    vld_nxt   = 1'b0;
                end else if (Redirect) begin
                    pc_nxt  = RedirectTarget;
                    ins_nxt = NOP_WORD;
                    vld_nxt = 1'b0;
                end else if (!Stall) begin
                    ins_nxt = Instruction;
                    pc4_nxt = pc_plus4;
                    vld_nxt = 1'b1;
                    pc_nxt  = pc_plus4;
                    if (FetchCount != '1)
                        cnt_nxt = FetchCount + COUNT_WIDTH'(1);
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= BOOT;
            pc               <= RESET_PC;
            IFID_Instruction <= NOP_WORD;
            IFID_PC_4        <= '0;
            IFID_Valid       <= 1'b0;
            FetchCount       <= '0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            IFID_Instruction <= ins_nxt;
            IFID_PC_4        <= pc4_nxt;
            IFID_Valid       <= vld_nxt;
            FetchCount       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random stimulus against a behavioural model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic [31:0] Instruction, PCAddress, IFID_Instruction, IFID_PC_4;
    logic        IFID_Valid, FetchFault;
    logic [15:0] FetchCount;

    logic [31:0] instr_n, pc_n, ins_n, pc4_n;
    logic        vld_n, flt_n;
    logic [3:0]  cnt_n;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model of the stage
    logic [31:0] m_pc, m_ins, m_pc4;
    bit          m_vld, m_flt, m_boot, m_pc4_known;
    int          m_cnt;

    always #5 clk = ~clk;

    // Program ROM: ROM[i] = 0x1000_0000 + i inside the 32-word window
    function automatic logic [31:0] rom_at(input logic [31:0] a);
        if (a[1:0] == 2'b00 && a < 32'd128) return 32'h1000_0000 + (a >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    assign Instruction = rom_at(PCAddress);
    assign instr_n     = rom_at(pc_n);

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .Instruction(Instruction),
        .PCAddress(PCAddress), .IFID_Instruction(IFID_Instruction),
        .IFID_PC_4(IFID_PC_4), .IFID_Valid(IFID_Valid),
        .FetchFault(FetchFault), .FetchCount(FetchCount)
    );

    instruction_fetch_stage #(.COUNT_WIDTH(4)) dut_n (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectTarget(RedirectTarget), .Instruction(instr_n),
        .PCAddress(pc_n), .IFID_Instruction(ins_n),
        .IFID_PC_4(pc4_n), .IFID_Valid(vld_n),
        .FetchFault(flt_n), .FetchCount(cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit rd, input logic [31:0] tg);
        if (rst) begin
            m_pc = 0; m_ins = 0; m_pc4 = 0; m_vld = 0; m_flt = 0; m_cnt = 0;
            m_boot = 1; m_pc4_known = 1;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_flt) begin
            // frozen until reset
        end else if ((m_pc % 4) != 0 || m_pc >= 32'd128) begin
            m_flt = 1; m_ins = 0; m_vld = 0;
        end else if (rd) begin
            m_pc = tg; m_ins = 0; m_vld = 0;
        end else if (!st) begin
            m_ins = rom_at(m_pc); m_pc4 = m_pc + 4; m_vld = 1;
            m_pc = m_pc + 4; m_cnt++; m_pc4_known = 1;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] tg);
        reset = rst; Stall = st; Redirect = rd; RedirectTarget = tg;
        @(posedge clk);
        model_edge(rst, st, rd, tg);
        #1;
        check("pc", PCAddress, m_pc);
        check("ins", IFID_Instruction, m_ins);
        check("vld", {31'b0, IFID_Valid}, {31'b0, m_vld});
        check("fault", {31'b0, FetchFault}, {31'b0, m_flt});
        check("cnt16", {16'b0, FetchCount}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        check("cnt4", {28'b0, cnt_n}, (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
        check("pc_n", pc_n, m_pc);
        if (m_pc4_known) check("pc4", IFID_PC_4, m_pc4);
    endtask

    initial begin
        m_pc4_known = 0;
        // 1: reset, boot cycle, free run
        step(1, 0, 0, 0);
        check("rst_pc", PCAddress, 32'h0);
        check("rst_pc4", IFID_PC_4, 32'h0);
        check("rst_vld", {31'b0, IFID_Valid}, 32'h0);
        step(0, 1, 1, 32'h40);
        check("boot_pc", PCAddress, 32'h0);
        check("boot_vld", {31'b0, IFID_Valid}, 32'h0);
        step(0, 0, 0, 0);
        check("t1_ins0", IFID_Instruction, 32'h1000_0000);
        check("t1_pc4_0", IFID_PC_4, 32'h4);
        check("t1_pc", PCAddress, 32'h4);
        step(0, 0, 0, 0);
        check("t1_ins1", IFID_Instruction, 32'h1000_0001);
        check("t1_pc4_1", IFID_PC_4, 32'h8);
        check("t1_cnt", {16'b0, FetchCount}, 32'd2);
        // 2: stall two cycles at PC=8
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("t2_pc", PCAddress, 32'h8);
        check("t2_ins", IFID_Instruction, 32'h1000_0001);
        check("t2_cnt", {16'b0, FetchCount}, 32'd2);
        step(0, 0, 0, 0);
        check("t2_rel_ins", IFID_Instruction, 32'h1000_0002);
        check("t2_rel_pc4", IFID_PC_4, 32'hC);
        // 3: redirect beats stall
        step(0, 1, 1, 32'h14);
        check("t3_pc", PCAddress, 32'h14);
        check("t3_vld", {31'b0, IFID_Valid}, 32'h0);
        check("t3_nop", IFID_Instruction, 32'h0);
        step(0, 0, 0, 0);
        check("t3_ins", IFID_Instruction, 32'h1000_0005);
        check("t3_pc4", IFID_PC_4, 32'h18);
        // 4: run off the end of memory
        for (int i = 0; i < 40 && !FetchFault; i++) step(0, 0, 0, 0);
        check("t4_fault", {31'b0, FetchFault}, 32'h1);
        check("t4_pc", PCAddress, 32'h80);
        check("t4_cnt", {16'b0, FetchCount}, 32'd30);
        step(0, 0, 1, 32'h0);
        check("t4_redir_ign", PCAddress, 32'h80);
        step(1, 0, 0, 0);
        check("t4_rst_fault", {31'b0, FetchFault}, 32'h0);
        // 5: misaligned redirect target
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h6);
        check("t5_pc", PCAddress, 32'h6);
        step(0, 0, 0, 0);
        check("t5_fault", {31'b0, FetchFault}, 32'h1);
        check("t5_cnt", {16'b0, FetchCount}, 32'd0);
        // 6: reset mid-run, then counter saturation
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("t6_cnt10", {16'b0, FetchCount}, 32'd10);
        step(1, 0, 0, 0);
        check("t6_rst_cnt", {16'b0, FetchCount}, 32'd0);
        check("t6_rst_vld", {31'b0, IFID_Valid}, 32'h0);
        check("t6_rst_pc4", IFID_PC_4, 32'h0);
        step(0, 0, 0, 0);
        check("t6_boot_pc", PCAddress, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check("t6_sat4", {28'b0, cnt_n}, 32'd15);
        check("t6_cnt20", {16'b0, FetchCount}, 32'd20);
        // Random phase against the model
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            bit r, s, d;
            r  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 9) == 0);
            tg = 32'($urandom_range(0, 40)) * 4;
            if ($urandom_range(0, 7) == 0) tg = tg | 32'($urandom_range(1, 3));
            step(r, s, d, tg);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
